// File: rtl/iq_page_streamer_if.sv
// iq_page_streamer byte channel toward the USB FIFO writer.
// A byte moves on a cycle where tx_valid and tx_ready are both high.
interface iq_page_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/iq_page_streamer.sv
// iq_page_streamer: packs completed adc_ram pages into framed USB byte packets.
// Define IQ_STREAM_CHECKSUM_EN to append an XOR checksum trailer byte.
module iq_page_streamer #(
  parameter logic [7:0] SYNC = 8'h7E
) (
  input  logic                usb_clock,
  input  logic                m_reset,
  input  logic                stream_en,
  input  logic                page_sel,
  output logic [7:0]          ram_rd_addr,
  input  logic [47:0]         ram_rd_data,
  input  logic                clip,
  iq_page_streamer_if.master  tx,
  output logic                overrun
);

`ifdef IQ_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD, TRAIL
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD
  } state_t;
`endif

  state_t      state;
  logic [2:0]  psync;
  logic        pg_edge;
  logic        pend;
  logic        pend_pg;
  logic        pg;
  logic        drop;
  logic        clip_seen;
  logic [7:0]  seq;
  logic [1:0]  hcnt;
  logic [2:0]  bcnt;
  logic [6:0]  wcnt;
  logic        last_out;
`ifdef IQ_STREAM_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic [7:0]  ridx;
  logic [2:0]  sh;
  logic [47:0] fifo [4];
  logic [1:0]  wp;
  logic [1:0]  rp;
  logic [2:0]  fcnt;
  logic [2:0]  inflight;
  logic [47:0] head;

  logic        load;
  logic        fin;
  logic        start;
  logic        idle_drop;
  logic        drop_ev;
  logic        issue;
  logic        emit;
  logic        fifo_pop;
  logic        flags_ld;
  logic [7:0]  nxt_byte;

  assign pg_edge   = psync[1] ^ psync[2];
  assign load      = !tx.tx_valid || tx.tx_ready;
  assign fin       = last_out && tx.tx_valid && tx.tx_ready;
  assign start     = stream_en && pend && (state == IDLE || fin);
  assign idle_drop = (state == IDLE) && !stream_en;
  assign drop_ev   = pg_edge && pend && !start && !idle_drop;
  assign inflight  = {2'b0, sh[0]} + {2'b0, sh[1]} + {2'b0, sh[2]};
  assign head      = fifo[rp];
  assign issue     = (state == HDR || state == PAYLOAD) && !ridx[7]
                     && ((fcnt + inflight) < 3'd4);

  // Select the next byte to load into the output register.
  always_comb begin
    emit     = 1'b0;
    fifo_pop = 1'b0;
    flags_ld = 1'b0;
    nxt_byte = 8'h00;
    unique case (state)
      HDR: begin
        emit = load;
        unique case (hcnt)
          2'd0:    nxt_byte = SYNC;
          2'd1:    nxt_byte = SYNC;
          2'd2:    nxt_byte = seq;
          default: nxt_byte = {6'b0, drop, clip_seen};
        endcase
        flags_ld = load && (hcnt == 2'd3);
      end
      PAYLOAD: begin
        if (!last_out && fcnt != 3'd0) begin
          emit     = load;
          fifo_pop = load && (bcnt == 3'd5);
          unique case (bcnt)
            3'd0:    nxt_byte = head[47:40];
            3'd1:    nxt_byte = head[39:32];
            3'd2:    nxt_byte = head[31:24];
            3'd3:    nxt_byte = head[23:16];
            3'd4:    nxt_byte = head[15:8];
            default: nxt_byte = head[7:0];
          endcase
        end
      end
`ifdef IQ_STREAM_CHECKSUM_EN
      TRAIL: begin
        emit     = load && !last_out;
        nxt_byte = csum;
      end
`endif
      default: ;
    endcase
  end

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge usb_clock or negedge m_reset) begin
    if (!m_reset) begin
      psync <= 3'b000;
    end else begin
      psync <= {psync[1:0], page_sel};
    end
  end

  // Single pending-page slot, overrun pulse and sticky header flags.
  always_ff @(posedge usb_clock or negedge m_reset) begin
    if (!m_reset) begin
      pend      <= 1'b0;
      pend_pg   <= 1'b0;
      overrun   <= 1'b0;
      drop      <= 1'b0;
      clip_seen <= 1'b0;
    end else begin
      overrun <= drop_ev;
      if (idle_drop) begin
        pend <= 1'b0;
      end else if (pg_edge) begin
        pend    <= 1'b1;
        pend_pg <= ~psync[1];
      end else if (start) begin
        pend <= 1'b0;
      end
      drop      <= (drop && !flags_ld) || drop_ev;
      clip_seen <= (clip_seen && !flags_ld) || (clip && stream_en);
    end
  end

  // Packet FSM with the registered byte output.
  always_ff @(posedge usb_clock or negedge m_reset) begin
    if (!m_reset) begin
      state       <= IDLE;
      seq         <= 8'h00;
      pg          <= 1'b0;
      hcnt        <= 2'd0;
      bcnt        <= 3'd0;
      wcnt        <= 7'd0;
      last_out    <= 1'b0;
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
`ifdef IQ_STREAM_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else begin
      if (load) begin
        tx.tx_valid <= emit;
        if (emit) tx.tx_data <= nxt_byte;
      end
      if (fin) begin
        last_out <= 1'b0;
        seq      <= seq + 8'd1;
      end
`ifdef IQ_STREAM_CHECKSUM_EN
      if (emit) csum <= csum ^ nxt_byte;
`endif
      if (start) begin
        state <= HDR;
        pg    <= pend_pg;
        hcnt  <= 2'd0;
        bcnt  <= 3'd0;
        wcnt  <= 7'd0;
`ifdef IQ_STREAM_CHECKSUM_EN
        csum  <= 8'h00;
`endif
      end else if (fin) begin
        state <= IDLE;
      end else begin
        unique case (state)
          HDR: begin
            if (emit) begin
              hcnt <= hcnt + 2'd1;
              if (hcnt == 2'd3) state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (emit) begin
              if (bcnt == 3'd5) begin
                bcnt <= 3'd0;
                wcnt <= wcnt + 7'd1;
                if (wcnt == 7'd127) begin
`ifdef IQ_STREAM_CHECKSUM_EN
                  state <= TRAIL;
`else
                  last_out <= 1'b1;
`endif
                end
              end else begin
                bcnt <= bcnt + 3'd1;
              end
            end
          end
`ifdef IQ_STREAM_CHECKSUM_EN
          TRAIL: begin
            if (emit) last_out <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // RAM read issue, latency tracking and word FIFO bookkeeping.
  always_ff @(posedge usb_clock or negedge m_reset) begin
    if (!m_reset) begin
      ram_rd_addr <= 8'h00;
      ridx        <= 8'h00;
      sh          <= 3'b000;
      wp          <= 2'd0;
      rp          <= 2'd0;
      fcnt        <= 3'd0;
    end else begin
      sh <= {sh[1:0], issue};
      if (start) begin
        ridx <= 8'h00;
        wp   <= 2'd0;
        rp   <= 2'd0;
        fcnt <= 3'd0;
      end else begin
        if (issue) begin
          ram_rd_addr <= {pg, ridx[6:0]};
          ridx        <= ridx + 8'd1;
        end
        if (sh[2]) wp <= wp + 2'd1;
        if (fifo_pop) rp <= rp + 2'd1;
        fcnt <= fcnt + {2'b0, sh[2]} - {2'b0, fifo_pop};
      end
    end
  end

  // Word storage; occupancy is tracked by the pointers above.
  always_ff @(posedge usb_clock) begin
    if (sh[2]) fifo[wp] <= ram_rd_data;
  end

endmodule

// File: doc/iq_page_streamer.md
IQ_PAGE_STREAMER -- requirements
Module: iq_page_streamer

Interface
REQ-001 Parameter SYNC, default 8'h7E, value of each of the two header sync bytes.
REQ-002 usb_clock  in  1  sole clock; all logic is on its rising edge.
REQ-003 m_reset  in  1  asynchronous, active-low reset.
REQ-004 stream_en  in  1  enables packet generation (rx_on).
REQ-005 page_sel  in  1  page currently being filled by the receiver (adc_ram_block), clock_76M domain.
REQ-006 ram_rd_addr  out  8  adc_ram read address {page, word[6:0]}.
REQ-007 ram_rd_data  in  48  adc_ram word {I[23:0], Q[23:0]}; valid 2 cycles after ram_rd_addr.
REQ-008 clip  in  1  ADC overload indication (level).
REQ-009 tx_data  out  8  byte to USB FIFO writer.
REQ-010 tx_valid  out  1  tx_data holds a valid byte.
REQ-011 tx_ready  in  1  writer accepts the byte; a transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-012 overrun  out  1  one-cycle pulse for each completed page dropped.

Function
REQ-013 page_sel SHALL pass through a 2-flop synchroniser; any edge of the synchronised value marks page ~new_value as complete and pending.
REQ-014 One pending slot SHALL exist; a page completion while the slot is already full SHALL replace the slot, pulse overrun, and set a sticky drop flag.
REQ-015 States: IDLE, HDR, PAYLOAD, TRAIL (TRAIL only with macro); reset state IDLE.
REQ-016 IDLE->HDR when stream_en=1 and the slot is pending; the slot is consumed and the page latched on that cycle.
REQ-017 HDR SHALL emit 4 bytes: SYNC, SYNC, seq[7:0], flags = {6'b0, drop, clip_seen}.
REQ-018 drop and clip_seen SHALL clear when flags is accepted; a clip during that cycle or a drop after it counts toward the next packet.
REQ-019 PAYLOAD SHALL emit 128 words x 6 bytes, word 0 first, per word I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
REQ-020 RAM reads SHALL be prefetched so that tx_valid stays high with no bubble while tx_ready=1 (sustained 1 byte/cycle).
REQ-021 Once tx_valid=1, tx_data SHALL stay stable and tx_valid SHALL stay high until the byte is accepted.
REQ-022 seq SHALL increment by 1 (mod 256, 8'hFF->8'h00) after each completed packet.
REQ-023 After the last byte is accepted: TRAIL if enabled, else IDLE; on the same cycle, start the next packet if it is pending.
REQ-024 stream_en falling mid-packet SHALL NOT truncate the packet; when it is low in IDLE, pending pages SHALL be discarded without an overrun pulse.
REQ-025 clip_seen SHALL be set on any cycle with clip=1 while stream_en=1.

Reset
REQ-026 While m_reset=0: tx_valid=0, tx_data=0, ram_rd_addr=0, overrun=0, seq=0, slot empty, drop=0, clip_seen=0, state IDLE, synchroniser cleared.
REQ-027 Reset asserted mid-packet SHALL abort immediately; after release, no partial packet is resumed.
REQ-028 The first page edge after reset SHALL be handled as a normal completion.

Configuration
REQ-029 With IQ_STREAM_CHECKSUM_EN defined, TRAIL SHALL emit one byte: the XOR of all 772 preceding packet bytes; the packet is 773 bytes.
REQ-030 Without IQ_STREAM_CHECKSUM_EN, TRAIL and its logic SHALL be absent; the packet is 772 bytes.

Verification
REQ-031 RAM word n = {24'h100000+n, 24'h200000+n}, stream_en=1, tx_ready=1, page_sel 0->1 -> bytes 7E 7E 00 00, 10 00 00 20 00 00, ..., ending 10 00 7F 20 00 7F; 772 consecutive valid cycles.
REQ-032 Same stimulus with tx_ready toggled randomly -> identical byte sequence; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-033 Three page edges during one packet -> overrun pulses twice; next header flags=8'h02; only the last page is sent next.
REQ-034 clip pulsed once in packet k -> flags bit0=1 in packet k+1 only; seq after 256 packets reads 8'h00.
REQ-035 m_reset low at byte 300 -> tx_valid=0 within the same cycle; after release plus a page edge, the packet starts with seq=00.
REQ-036 With IQ_STREAM_CHECKSUM_EN, the REQ-031 stimulus -> byte 773 equals the XOR of bytes 1-772.
